// File: rtl/rr_decoder_arbiter_pkg.sv
// Shared types, sizes and the rotating winner search for the round-robin arbiter.
package rr_decoder_arbiter_pkg;

  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;

  typedef logic [IDX_W-1:0]   idx_t;
  typedef logic [NUM_REQ-1:0] req_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  // First asserted request in the order last+1, last+2, last+3, last+4 (mod 4).
  // The loop runs from the farthest candidate to the nearest, so the nearest wins.
  function automatic idx_t rr_pick(input req_t req, input idx_t last);
    idx_t cand;
    idx_t pick;
    pick = last;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = last + idx_t'(k) + idx_t'(1);
      if (req[cand]) pick = cand;
    end
    return pick;
  endfunction

endpackage

// File: rtl/rr_decoder_arbiter_if.sv
// Request/grant bundle between requesters (master side) and the arbiter (slave side).
interface rr_decoder_arbiter_if;
  import rr_decoder_arbiter_pkg::*;

  req_t req;
  req_t grant;
  idx_t grant_idx;
  logic grant_valid;
  logic preempt;

  modport master (output req, input grant, grant_idx, grant_valid, preempt);
  modport slave  (input req, output grant, grant_idx, grant_valid, preempt);
endinterface

// File: rtl/rr_decoder_arbiter_decoder.sv
// Existing 2-to-4 one-hot decoder reused for grant line generation.
module Decoder (
  output logic [3:0] D,
  input  logic [1:0] S
);

  // One-hot expansion of the select index.
  always_comb begin
    D = 4'b0001 << S;
  end

endmodule

// File: rtl/rr_decoder_arbiter.sv
// Four-requester round-robin arbiter with a bounded hold counter that forces a
// handoff once a holder has used MAX_HOLD consecutive cycles while others wait.
module rr_decoder_arbiter
  import rr_decoder_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 3
) (
  input logic                 clk,
  input logic                 rst,
  rr_decoder_arbiter_if.slave bus
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  state_e           state_q, state_d;
  idx_t             idx_q, idx_d;
  idx_t             last_q, last_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic             preempt_q, preempt_d;
  req_t             others;
  logic [3:0]       dec_onehot;

  // Next-state: idle acquisition, hold/saturate, release handoff, forced preemption.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    idx_d     = idx_q;
    last_d    = last_q;
    hold_d    = hold_q;
    preempt_d = 1'b0;
    others    = bus.req & ~(req_t'(1) << idx_q);

    case (state_q)
      ST_IDLE: begin
        hold_d = '0;
        if (|bus.req) begin
          state_d = ST_GRANT;
          idx_d   = rr_pick(bus.req, last_q);
        end
      end
      ST_GRANT: begin
        if (!bus.req[idx_q]) begin
          // Release wins over any simultaneous new requests; hand off with no bubble.
          last_d = idx_q;
          hold_d = '0;
          if (|others) idx_d = rr_pick(others, idx_q);
          else         state_d = ST_IDLE;
        end else if ((|others) && (hold_q == HOLD_LAST)) begin
          // Forced handoff: the holder drops to lowest priority and re-queues.
          last_d    = idx_q;
          idx_d     = rr_pick(others, idx_q);
          preempt_d = 1'b1;
          hold_d    = '0;
        end else if (hold_q != HOLD_LAST) begin
          hold_d = hold_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register with synchronous reset; req[0] has top priority after reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      last_q    <= idx_t'(NUM_REQ - 1);
      hold_q    <= '0;
      preempt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      last_q    <= last_d;
      hold_q    <= hold_d;
      preempt_q <= preempt_d;
    end
  end

  Decoder u_decoder (
    .D (dec_onehot),
    .S (idx_q)
  );

  assign bus.grant       = dec_onehot & {NUM_REQ{state_q == ST_GRANT}};
  assign bus.grant_idx   = idx_q;
  assign bus.grant_valid = (state_q == ST_GRANT);
  assign bus.preempt     = preempt_q;

endmodule

// File: tb/tb_rr_decoder_arbiter.sv
// Self-checking bench: directed stimulus, literal expectations, and a cycle model
// of the arbitration rules compared against the DUT on every falling edge.
module tb_rr_decoder_arbiter;

  localparam int MAX_HOLD = 8;

  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;
  logic model_on;

  rr_decoder_arbiter_if bus ();

  rr_decoder_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  // Model: holder, whether a grant is active, the last handed-off index and
  // how many consecutive cycles the current holder has had the grant.
  int m_holder;
  int m_last;
  int m_tenure;
  bit m_valid;
  bit m_preempt;

  function automatic int pick(input logic [3:0] r, input int last);
    for (int off = 1; off <= 4; off++) begin
      if (r[(last + off) % 4]) return (last + off) % 4;
    end
    return last;
  endfunction

  always @(posedge clk) begin
    logic [3:0] r;
    logic [3:0] oth;
    r = bus.req;
    if (rst) begin
      m_valid = 0; m_holder = 0; m_last = 3; m_tenure = 0; m_preempt = 0;
    end else if (!m_valid) begin
      m_preempt = 0;
      if (r != 4'b0000) begin
        m_holder = pick(r, m_last);
        m_valid  = 1;
        m_tenure = 1;
      end
    end else begin
      oth = r;
      oth[m_holder] = 1'b0;
      m_preempt = 0;
      if (!r[m_holder]) begin
        m_last = m_holder;
        if (oth != 4'b0000) begin
          m_holder = pick(oth, m_last);
          m_tenure = 1;
        end else begin
          m_valid = 0;
        end
      end else if (oth != 4'b0000 && m_tenure >= MAX_HOLD) begin
        m_last    = m_holder;
        m_holder  = pick(oth, m_last);
        m_preempt = 1;
        m_tenure  = 1;
      end else begin
        m_tenure++;
      end
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      check("model_valid",   {3'b000, bus.grant_valid}, {3'b000, m_valid});
      check("model_preempt", {3'b000, bus.preempt},     {3'b000, m_preempt});
      check("model_grant",   bus.grant, m_valid ? 4'(1 << m_holder) : 4'b0000);
      if (m_valid) check("model_idx", {2'b00, bus.grant_idx}, 4'(m_holder));
    end
  end

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    model_on     = 1'b0;
    bus.req      = 4'b0000;
    rst          = 1'b1;
    repeat (2) @(negedge clk);
    model_on = 1'b1;
    check("rst_grant",   bus.grant, 4'b0000);
    check("rst_valid",   {3'b000, bus.grant_valid}, 4'b0000);
    check("rst_idx",     {2'b00, bus.grant_idx}, 4'b0000);
    check("rst_preempt", {3'b000, bus.preempt}, 4'b0000);
    rst = 1'b0;

    // No requests: stays idle.
    repeat (3) begin
      @(negedge clk);
      check("idle_grant", bus.grant, 4'b0000);
      check("idle_valid", {3'b000, bus.grant_valid}, 4'b0000);
      check("idle_preempt", {3'b000, bus.preempt}, 4'b0000);
    end

    // All request: 0 first, then preemption every MAX_HOLD cycles, wrapping 3->0.
    bus.req = 4'b1111;
    @(negedge clk);
    check("all_first_grant", bus.grant, 4'b0001);
    check("all_first_idx", {2'b00, bus.grant_idx}, 4'b0000);
    repeat (8) @(negedge clk);
    check("preempt_to1_grant", bus.grant, 4'b0010);
    check("preempt_to1_pulse", {3'b000, bus.preempt}, 4'b0001);
    repeat (8) @(negedge clk);
    check("preempt_to2_grant", bus.grant, 4'b0100);
    repeat (8) @(negedge clk);
    check("preempt_to3_grant", bus.grant, 4'b1000);
    repeat (8) @(negedge clk);
    check("preempt_wrap_grant", bus.grant, 4'b0001);
    check("preempt_wrap_pulse", {3'b000, bus.preempt}, 4'b0001);

    // Lone requester keeps the grant indefinitely, never preempted.
    bus.req = 4'b0100;
    repeat (20) begin
      @(negedge clk);
      check("lone_grant", bus.grant, 4'b0100);
      check("lone_preempt", {3'b000, bus.preempt}, 4'b0000);
    end

    // Release handoff with no bubble, then release to idle.
    bus.req = 4'b0000;
    repeat (2) @(negedge clk);
    check("back_idle_valid", {3'b000, bus.grant_valid}, 4'b0000);
    bus.req = 4'b0010;
    @(negedge clk);
    check("holder1_grant", bus.grant, 4'b0010);
    bus.req = 4'b1010;
    @(negedge clk);
    check("holder1_keep", bus.grant, 4'b0010);
    bus.req = 4'b1000;
    @(negedge clk);
    check("release_no_bubble", bus.grant, 4'b1000);
    bus.req = 4'b0000;
    @(negedge clk);
    check("release_to_idle", bus.grant, 4'b0000);

    // Reset in the middle of a grant (holder 2, hold count 5).
    bus.req = 4'b0100;
    @(negedge clk);
    check("pre_rst_grant", bus.grant, 4'b0100);
    repeat (5) @(negedge clk);
    bus.req = 4'b0111;
    rst     = 1'b1;
    @(negedge clk);
    check("midrst_grant",   bus.grant, 4'b0000);
    check("midrst_valid",   {3'b000, bus.grant_valid}, 4'b0000);
    check("midrst_idx",     {2'b00, bus.grant_idx}, 4'b0000);
    check("midrst_preempt", {3'b000, bus.preempt}, 4'b0000);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_grant", bus.grant, 4'b0001);

    // Holder 0 releases while req[2] rises in the same cycle.
    bus.req = 4'b0001;
    @(negedge clk);
    check("holder0_grant", bus.grant, 4'b0001);
    bus.req = 4'b0100;
    @(negedge clk);
    check("swap_grant", bus.grant, 4'b0100);
    check("swap_preempt", {3'b000, bus.preempt}, 4'b0000);

    // One-cycle request pulse wins one grant cycle, then is released.
    bus.req = 4'b0000;
    @(negedge clk);
    check("pulse_pre_idle", bus.grant, 4'b0000);
    bus.req = 4'b1000;
    @(negedge clk);
    bus.req = 4'b0000;
    check("pulse_grant", bus.grant, 4'b1000);
    @(negedge clk);
    check("pulse_release", bus.grant, 4'b0000);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/rr_decoder_arbiter.md
Name: rr_decoder_arbiter

Overview:
- Four-requester round-robin arbiter that shares one downstream resource.
- Produces a registered 2-bit grant index and drives the existing combinational `Decoder` (2-to-4) to form the one-hot grant vector.
- A bounded hold counter preempts a long-running holder, so no requester starves.
- Sits between requesting blocks and the shared datapath; its one-hot grant doubles as select/enable lines.

Parameters:
- MAX_HOLD, 8: maximum consecutive grant cycles a holder keeps while others are waiting. Legal values ≥ 2.
- CNT_W, 3: hold counter width. Must satisfy 2^CNT_W ≥ MAX_HOLD.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- req  input  4  request lines; req[i] is held high while requester i wants or uses the resource
- grant  output  4  one-hot grant, all zero when grant_valid=0
- grant_idx  output  2  index of current holder; meaningful only when grant_valid=1
- grant_valid  output  1  a grant is active
- preempt  output  1  one-cycle pulse in the cycle the new grant appears after a forced handoff

Behaviour:
- All state is registered; rst is sampled only on the rising clk edge.
- Reset values:
  - grant_idx=0, grant_valid=0, grant=4'b0000, preempt=0.
  - Internal last_idx=3 (req[0] has top priority after reset), hold_cnt=0, state IDLE.
- Reset asserted mid-grant: all outputs return to reset values on that edge; no handoff or preempt pulse is generated.
- Winner selection:
  - Search in rotating order last_idx+1, +2, +3, +4 (mod 4) and take the first asserted req.
  - Index arithmetic is 2-bit and wraps 3→0.
- State IDLE (grant_valid=0):
  - If any req is high at edge k, grant_valid=1 with the winner's index from edge k+1 (1-cycle latency).
  - hold_cnt=0.
- State GRANT (holder h = grant_idx):
  - Holder keeps it: req[h]=1 and either no other req is high, or hold_cnt < MAX_HOLD-1. hold_cnt increments and saturates at MAX_HOLD-1. With no competitors the holder keeps the grant indefinitely.
  - Release: req[h]=0.
    - last_idx←h.
    - If other reqs are high, the new winner is granted at the next edge with no bubble cycle.
    - If no reqs are high, go to IDLE (grant_valid=0 next cycle).
    - hold_cnt←0.
  - Preempt: req[h]=1, hold_cnt == MAX_HOLD-1, and another req is high.
    - last_idx←h; the winner among the others gets the grant next edge.
    - preempt=1 for exactly that one cycle; hold_cnt←0.
    - h is now lowest priority and keeps req asserted to re-queue.
- Simultaneous events:
  - Release and new requests in the same cycle are handled as a release.
  - A requester whose req rises in the same cycle as a handoff takes part in that handoff.
- A req pulse shorter than one cycle, or one that drops before its grant appears, may still win one cycle of grant. That grant is released on the following edge.
- grant equals Decoder(grant_idx) ANDed with grant_valid, so exactly one bit is high when valid, else zero.

Decomposition:
- Shared include `arb_defs.vh`:
  - state encodings ST_IDLE=1'b0, ST_GRANT=1'b1
  - NUM_REQ=4, IDX_W=2
- Sub-module: reuse the existing `Decoder` (ports D[3:0], S[1:0]), instantiated once for one-hot generation. No new sub-module.
- Winner search is a combinational function or always block inside rr_decoder_arbiter.

Test Plan:
- Reset, then req=4'b0000 for 3 cycles → grant=0000, grant_valid=0, preempt=0 throughout.
- After reset, req=4'b1111 → one cycle later grant=0001, grant_idx=0.
  - Hold 8 cycles: preempt pulses and grant=0010.
  - After 8 more: grant=0100, then 1000, then 0001 (wraps 3→0).
- req=4'b0100 alone for 20 cycles → grant=0100 continuously, preempt never asserts.
- Holder 1 active with req=4'b1010; drop req[1] → next cycle grant=1000 with no zero-grant bubble.
  - Then drop req[3] → grant=0000 next cycle.
- Grant held by 2 with req=4'b0111 at hold_cnt=5; assert rst for one cycle → next cycle all outputs at reset values.
  - With req still 0111, grant=0001 one cycle after rst deasserts.
- Holder 0 drops req[0] while req[2] rises in the same cycle → next cycle grant=0100, preempt=0.
